// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data memory
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Byte lanes per word
  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Byte-offset bits inside a byte address
  function automatic int calc_ofs_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 0;
  endfunction

  // Even parity bit for one byte lane (lane plus bit has an even number of ones)
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_ram_sp.sv
// rtl/dmem_ram_sp.sv - single-port word array with byte-lane writes, combinational read
module dmem_ram_sp #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [LANES-1:0]          be,
  input  logic [IDX_W-1:0]          idx,
  input  logic [LANES*LANE_W-1:0]   wdata,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  // Lane-wise write; the caller guarantees idx is in range whenever we is set
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = (32'(idx) < DEPTH) ? mem[idx] : '0;

endmodule

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - handshaked data memory with clear sweep; DMEM_PARITY_EN adds lane parity
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  localparam int BE_W  = calc_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr_req,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              par_err
);

  localparam int OFS_W = calc_ofs_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int RAM_W = BE_W * LANE_W;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q;
  logic              sweep_done;
  logic [ADDR_W-1:0] word_idx;
  logic              addr_err;
  logic              accept;
  logic              par_hit;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [IDX_W-1:0]  ram_idx;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_rdata;
  logic [RAM_W-1:0]  req_lanes;
  logic [DATA_W-1:0] rd_data;
  logic              rd_par_bad;

  assign word_idx   = req_addr >> OFS_W;
  assign addr_err   = ((req_addr & ADDR_W'(BE_W - 1)) != '0) || (word_idx >= ADDR_W'(DEPTH));
  assign sweep_done = (state_q == CLEAR) && (clr_idx_q == IDX_W'(DEPTH - 1));
  assign accept     = req_valid && req_ready;
  assign par_hit    = accept && !req_we && !addr_err && rd_par_bad;

  // Pack request bytes into stored lanes and unpack/check the addressed word
  always_comb begin
    req_lanes  = '0;
    rd_data    = '0;
    rd_par_bad = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      req_lanes[i*LANE_W +: 8] = req_wdata[i*8 +: 8];
      rd_data[i*8 +: 8]        = ram_rdata[i*LANE_W +: 8];
`ifdef DMEM_PARITY_EN
      req_lanes[i*LANE_W + 8]  = parity8(req_wdata[i*8 +: 8]);
      rd_par_bad = rd_par_bad | (ram_rdata[i*LANE_W + 8] != parity8(ram_rdata[i*LANE_W +: 8]));
`endif
    end
  end

  // State register and sweep index; index rests at 0 outside the sweep
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= (state_q == CLEAR && !sweep_done) ? clr_idx_q + 1'b1 : '0;
    end
  end

  // Next state: the sweep ends on its last word, a clear pulse restarts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (sweep_done) state_d = IDLE;
      IDLE:    if (clr_req)    state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs and array port steering; the sweep owns the array while busy
  always_comb begin
    busy      = (state_q == CLEAR);
    req_ready = (state_q == IDLE) && !clr_req;
    ram_we    = accept && req_we && !addr_err;
    ram_be    = req_be;
    ram_idx   = word_idx[IDX_W-1:0];
    ram_wdata = req_lanes;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_idx   = clr_idx_q;
      ram_wdata = '0;
    end
  end

  // One-cycle registered response; everything drops to 0 between responses
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= addr_err || par_hit;
      rsp_rdata <= (!req_we && !addr_err) ? rd_data : '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

`ifdef DMEM_PARITY_EN
  // Sticky parity flag, cleared only when a sweep completes
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)          par_err <= 1'b0;
    else if (sweep_done) par_err <= 1'b0;
    else if (par_hit)    par_err <= 1'b1;
  end
`else
  assign par_err = 1'b0;
`endif

  dmem_ram_sp #(
    .LANE_W (LANE_W),
    .LANES  (BE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_hs.sv
// tb/tb_data_memory_hs.sv - randomized self-checking bench for data_memory_hs
module tb_data_memory_hs;

  localparam int DEPTH = 16;

  logic        clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        clr_req;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        par_err;

  int n_cmp;
  int n_fail;
  logic [31:0] model [DEPTH];

  data_memory_hs #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .clr_req   (clr_req),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic count_busy(input string tag, input int expected);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== expected) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d required %0d", tag, n, expected);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_after_sweep: got %b required 1", tag, req_ready);
    end
  endtask

  // One bus cycle starting and ending at a falling edge; checks ready and the response
  task automatic step(input logic v, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input string tag);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          idx;
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    #1;
    if (v) begin
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ready: got %b required 1", tag, req_ready);
      end
    end
    @(posedge clk);
    idx     = int'(addr / 4);
    exp_err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    exp_rd  = 32'h0;
    if (v && !we && !exp_err) exp_rd = model[idx];
    if (v && we && !exp_err) begin
      for (int b = 0; b < 4; b++) if (be[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== v || rsp_rdata !== exp_rd || rsp_err !== (v && exp_err)) begin
      n_fail++;
      $display("FAIL %s rsp: got v=%b d=%h e=%b required v=%b d=%h e=%b (addr %h we %b)",
               tag, rsp_valid, rsp_rdata, rsp_err, v, exp_rd, v && exp_err, addr, we);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b rdy=%b v=%b d=%h e=%b pe=%b required 1 0 0 0 0 0",
               busy, req_ready, rsp_valid, rsp_rdata, rsp_err, par_err);
    end
    Reset = 1'b1;
    model_clear();
    count_busy("reset", DEPTH);
    step(1'b1, 1'b0, 32'h3C, 4'h0, 32'h0, "reset_read_3c");
  endtask

  task automatic test_write_read_b2b();
    step(1'b1, 1'b1, 32'h8, 4'b0101, 32'hDEADBEEF, "b2b_write");
    step(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, "b2b_read");
    n_cmp++;
    if (model[2] !== 32'h00AD00EF) begin
      n_fail++;
      $display("FAIL b2b_model: got %h required 00ad00ef", model[2]);
    end
    step(1'b1, 1'b1, 32'h8, 4'b1010, 32'h11223344, "b2b_write2");
    step(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, "b2b_read2");
  endtask

  task automatic test_errors();
    step(1'b1, 1'b0, 32'h6, 4'h0, 32'h0, "err_misaligned");
    step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, "err_range");
    step(1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, "err_write_range");
    step(1'b1, 1'b1, 32'h9, 4'hF, 32'hCAFEF00D, "err_write_mis");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, "err_scan");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 'h4F));
      else if (r == 1) a = 32'($urandom_range(16, 63) * 4);
      else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
      step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), a,
           4'($urandom_range(0, 15)), $urandom, "random");
    end
    n_cmp++;
    if (par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL random_par_err: got %b required 0", par_err);
    end
  endtask

  task automatic test_clr_collision();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_be = 4'hF; req_wdata = 32'h12345678;
    clr_req = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_ready: got %b required 0", req_ready);
    end
    @(negedge clk);
    clr_req = 1'b0;
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_rsp: got %b required 0", rsp_valid);
    end
    model_clear();
    count_busy("collision", DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, "clear_scan");
  endtask

  task automatic test_reset_mid_sweep();
    step(1'b1, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, "mid_prewrite");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %b required 1", busy);
    end
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got busy=%b rdy=%b v=%b required 1 0 0", busy, req_ready, rsp_valid);
    end
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    model_clear();
    count_busy("mid_reset", DEPTH);
    step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "mid_read");
    step(1'b1, 1'b0, 32'h3C, 4'h0, 32'h0, "mid_read_last");
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b1, 32'h4, 4'hF, 32'h01020304, "par_write");
    dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_be = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h01020305) begin
      n_fail++;
      $display("FAIL par_read: got v=%b e=%b d=%h required 1 1 01020305", rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_sticky: got %b required 1", par_err);
    end
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_during_sweep: got %b required 1", par_err);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (par_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL par_after_sweep: got pe=%b busy=%b required 0 0", par_err, busy);
    end
    model_clear();
    step(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, "par_read_clean");
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_write_read_b2b();
    test_errors();
    test_random();
    test_clr_collision();
    test_reset_mid_sweep();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
